mod_exp_engine: RTL and testbench

RSA encrypt/decrypt datapath that consumes the key pair produced by key generation. It computes result = base^exponent mod modulus: encryption uses (m, e, n) and decryption uses (c, d, n). The block is a multi-cycle, constant-time, right-to-left square-and-multiply engine. It uses two interleaved shift-add modular multipliers and contains no hardware divider.

---
 rtl/mod_exp_if.sv | 24 ++
 rtl/mod_exp_engine.sv | 152 +++++++++++++++
 tb/tb_mod_exp_engine.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mod_exp_if.sv
// Request/response bundle for the modular exponentiation engine.
// The requester uses the master modport and the engine uses the slave modport.
interface mod_exp_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] exponent;
  logic [WIDTH-1:0] modulus;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, base, exponent, modulus,
    input  result, busy, done, err
  );

  modport slave (
    input  start, base, exponent, modulus,
    output result, busy, done, err
  );
endinterface

// File: rtl/mod_exp_engine.sv
// Constant-time right-to-left square-and-multiply: result = base^exponent mod modulus.
// Two shift-add modular multipliers share the old b as multiplier, one bit per cycle.
module mod_exp_engine #(
  parameter int WIDTH = 16
) (
  input logic      clk,
  input logic      rst_n,
  mod_exp_if.slave bus
);
  localparam int AW = WIDTH + 2;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, CHECK, REDUCE, EXP, FIN} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] base_q, exp_q, mod_q;
  logic [WIDTH-1:0] r_q, b_q, result_q;
  logic [AW-1:0]    acc_a, acc_b;
  logic [AW-1:0]    step_a, step_b, add_a, n_ext;
  logic [CW-1:0]    bit_cnt, ei;
  logic             mul_bit, busy_q, done_q, err_q;

  // One MSB-first shift-add step; inputs below n keep the result below n.
  function automatic logic [AW-1:0] mm_step(input logic [AW-1:0] acc,
                                            input logic [AW-1:0] addend,
                                            input logic [AW-1:0] n,
                                            input logic          bit_i);
    logic [AW-1:0] t;
    t = acc << 1;
    if (t >= n) t = t - n;
    if (bit_i) begin
      t = t + addend;
      if (t >= n) t = t - n;
    end
    return t;
  endfunction

  always_comb begin
    n_ext   = {2'b00, mod_q};
    mul_bit = 1'b0;
    add_a   = '0;
    case (state)
      REDUCE: begin
        mul_bit = base_q[bit_cnt];
        add_a   = AW'(1);
      end
      EXP: begin
        mul_bit = b_q[bit_cnt];
        add_a   = {2'b00, r_q};
      end
      default: ;
    endcase
    step_a = mm_step(acc_a, add_a, n_ext, mul_bit);
    step_b = mm_step(acc_b, {2'b00, b_q}, n_ext, b_q[bit_cnt]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = CHECK;
      CHECK:   state_nx = (mod_q < WIDTH'(2)) ? FIN : REDUCE;
      REDUCE:  if (bit_cnt == '0) state_nx = EXP;
      EXP:     if (bit_cnt == '0 && ei == CW'(WIDTH - 1)) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q   <= '0;
      exp_q    <= '0;
      mod_q    <= '0;
      r_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      acc_a    <= '0;
      acc_b    <= '0;
      bit_cnt  <= '0;
      ei       <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            base_q <= bus.base;
            exp_q  <= bus.exponent;
            mod_q  <= bus.modulus;
            busy_q <= 1'b1;
            err_q  <= 1'b0;
          end
        end
        CHECK: begin
          if (mod_q < WIDTH'(2)) begin
            result_q <= '0;
            err_q    <= 1'b1;
          end else begin
            r_q     <= WIDTH'(1);
            acc_a   <= '0;
            bit_cnt <= CW'(WIDTH - 1);
          end
        end
        REDUCE: begin
          if (bit_cnt == '0) begin
            b_q     <= step_a[WIDTH-1:0];
            acc_a   <= '0;
            acc_b   <= '0;
            ei      <= '0;
            bit_cnt <= CW'(WIDTH - 1);
          end else begin
            acc_a   <= step_a;
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        EXP: begin
          // End of a bit slot: commit the square always, the product only on a set exponent bit.
          if (bit_cnt == '0) begin
            b_q     <= step_b[WIDTH-1:0];
            if (exp_q[ei]) r_q <= step_a[WIDTH-1:0];
            acc_a   <= '0;
            acc_b   <= '0;
            ei      <= ei + 1'b1;
            bit_cnt <= CW'(WIDTH - 1);
          end else begin
            acc_a   <= step_a;
            acc_b   <= step_b;
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        FIN: begin
          result_q <= err_q ? '0 : r_q;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
endmodule

// File: tb/tb_mod_exp_engine.sv
// Scoreboard bench for mod_exp_engine: stimulus pushes expected responses,
// a negedge monitor pops and compares them whenever done pulses.
module tb_mod_exp_engine;
  localparam int W = 16;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           lat;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  mod_exp_if #(.WIDTH(W)) bus ();

  mod_exp_engine #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Reference: repeated multiplication with plain % arithmetic.
  function automatic logic [W-1:0] ref_modexp(longint b, longint e, longint m);
    longint r;
    if (m < 2) return '0;
    r = 1;
    for (longint i = 0; i < e; i++) r = (r * (b % m)) % m;
    return W'(r);
  endfunction

  always @(negedge clk) begin : monitor
    exp_t ent;
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
      end else begin
        ent = sb.pop_front();
        check("result", bus.result, ent.res);
        check("err", bus.err, ent.err);
        check("latency", cyc - ent.acc, ent.lat);
      end
    end
  end

  // Called at a negedge with the DUT idle; start is accepted at the next posedge.
  task automatic launch(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m);
    exp_t ent;
    bus.base     = b;
    bus.exponent = e;
    bus.modulus  = m;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    ent.res = ref_modexp(b, e, m);
    ent.err = (m < 2);
    ent.lat = (m < 2) ? 2 : 2 + W + W * W;
    ent.acc = cyc;
    sb.push_back(ent);
    check("busy_after_accept", bus.busy, 1);
    check("err_cleared_on_accept", bus.err, 0);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    bit seen = 0;
    bit busy_gap = 0;
    for (int i = 0; i < max_cyc; i++) begin
      if (bus.done) begin
        seen = 1;
        break;
      end
      if (!bus.busy) busy_gap = 1;
      @(negedge clk);
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=none required=done within %0d cycles", max_cyc);
      sb.delete();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
    end else begin
      check("busy_window", busy_gap, 0);
      check("busy_low_at_done", bus.busy, 0);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.base     = '0;
    bus.exponent = '0;
    bus.modulus  = '0;
    repeat (3) @(negedge clk);
    check("rst_result", bus.result, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    launch(16'd65, 16'd17, 16'd3233);
    wait_done(400);
    check("encrypt_value", bus.result, 2790);

    @(negedge clk);
    launch(16'd2790, 16'd2753, 16'd3233);
    wait_done(400);
    check("decrypt_value", bus.result, 65);
    launch(16'd65, 16'd17, 16'd3233);
    wait_done(400);

    @(negedge clk);
    launch(16'd123, 16'd0, 16'd3233);
    wait_done(400);
    @(negedge clk);
    launch(16'd5000, 16'd1, 16'd3233);
    wait_done(400);
    check("base_reduced", bus.result, 1767);
    @(negedge clk);
    launch(16'hFFFF, 16'hFFFF, 16'hFFFF);
    wait_done(400);
    @(negedge clk);
    launch(16'd2, 16'd15, 16'hFFF1);
    wait_done(400);
    @(negedge clk);
    launch(16'd0, 16'd77, 16'd3233);
    wait_done(400);

    @(negedge clk);
    launch(16'd65, 16'd17, 16'd1);
    wait_done(10);
    @(negedge clk);
    launch(16'd65, 16'd17, 16'd0);
    wait_done(10);
    @(negedge clk);
    launch(16'd65, 16'd17, 16'd3233);
    wait_done(400);

    // A start while busy and mid-run operand changes must be ignored.
    @(negedge clk);
    launch(16'd65, 16'd17, 16'd3233);
    repeat (49) @(negedge clk);
    bus.start    = 1'b1;
    bus.base     = 16'd7;
    bus.exponent = 16'd3;
    bus.modulus  = 16'd11;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.base     = 16'd1234;
    wait_done(400);

    @(negedge clk);
    launch(16'd65, 16'd17, 16'd3233);
    repeat (99) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_result", bus.result, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_err", bus.err, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    launch(16'd65, 16'd17, 16'd3233);
    wait_done(400);

    for (int k = 0; k < 12; k++) begin
      logic [W-1:0] rb, re, rm;
      @(negedge clk);
      rb = W'($urandom_range(0, 65535));
      re = W'($urandom_range(0, 65535));
      rm = (k % 4 == 0) ? W'($urandom_range(2, 255)) : W'($urandom_range(2, 65535));
      launch(rb, re, rm);
      wait_done(400);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
